// File: rtl/qif_synapse_accumulator.sv
// Synaptic current stage for the 8-bit QIF neuron. Each timestep it serially sums the
// weights of the active spike lines, then applies leak and saturation to the stored current.
module qif_synapse_accumulator #(
   parameter int DECAY_SHIFT = 3,
   parameter int N_IN        = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ena,
   input  logic            step,
   input  logic [N_IN-1:0] spike_in,
   input  logic            wr_en,
   input  logic [2:0]      wr_addr,
   input  logic [7:0]      wr_data,
   output logic [7:0]      i_syn,
   output logic            i_valid,
   output logic            busy,
   output logic            overrun
);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, UPDATE = 2'd2} state_t;

   state_t             state_q;
   logic signed [7:0]  weight_q [N_IN];
   logic [N_IN-1:0]    snap_q;
   logic signed [11:0] acc_q;
   logic [2:0]         idx_q;
   logic signed [7:0]  i_syn_q;
   logic               i_valid_q;
   logic               busy_q;

   logic signed [11:0] syn_ext;
   logic signed [11:0] leak;
   logic signed [11:0] w_ext;
   logic signed [11:0] i_syn_d;

   function automatic logic signed [7:0] sat8(input logic signed [11:0] v);
      if (v > 12'sd127)
         return 8'sh7F;
      else if (v < -12'sd128)
         return 8'sh80;
      else
         return v[7:0];
   endfunction

   always_comb begin
      syn_ext = {{4{i_syn_q[7]}}, i_syn_q};
      leak    = syn_ext >>> DECAY_SHIFT;
      w_ext   = {{4{weight_q[idx_q][7]}}, weight_q[idx_q]};
      i_syn_d = syn_ext - leak + acc_q;
   end

   // busy_q stays high one cycle past UPDATE so it covers the i_valid cycle;
   // that IDLE+busy cycle is where it gets cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         i_syn_q   <= '0;
         i_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         for (int k = 0; k < N_IN; k++) weight_q[k] <= '0;
      end else if (ena) begin
         i_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (busy_q) begin
                  busy_q <= 1'b0;
               end else begin
                  if (wr_en) weight_q[wr_addr] <= wr_data;
                  if (step) begin
                     snap_q  <= spike_in;
                     acc_q   <= '0;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (snap_q[idx_q]) acc_q <= acc_q + w_ext;
               idx_q <= idx_q + 3'd1;
               if (idx_q == 3'(N_IN - 1)) state_q <= UPDATE;
            end
            UPDATE: begin
               i_syn_q   <= sat8(i_syn_d);
               i_valid_q <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign i_syn   = i_syn_q;
   assign i_valid = i_valid_q & ena;
   assign busy    = busy_q;
   assign overrun = ena & step & busy_q & ~reset;

endmodule
